// File: rtl/overlap_add_pkg.sv
// Shared types and helpers for the overlap-add reconstruction block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (ACCUM/FLUSH), sat_s() width-generic signed saturation.
package overlap_add_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Widest sample width the saturation helper supports.
  localparam int SAT_MAXW = 64;

  // Clamp x to the signed range of a w-bit value. The caller
  // sign-extends its operand to SAT_MAXW+1 bits and truncates the result
  // back to w bits; w must not exceed SAT_MAXW.
  function automatic logic signed [SAT_MAXW-1:0] sat_s(
    input logic signed [SAT_MAXW:0] x,
    input int unsigned              w
  );
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (w - 1)) - one;
    lo     = -(one <<< (w - 1));
    if (x > hi)      return hi[SAT_MAXW-1:0];
    else if (x < lo) return lo[SAT_MAXW-1:0];
    else             return x[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port block RAM, read-first: a write returns the old word on douta.
// Latency: 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE).
// Backpressure: none; ena gates both access and the output register.
// Ports: clka clock, ena enable, wea write enable, rsta sync output clear,
//        addra address, dina write data, douta read data.
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic                         rsta,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  // Contents are never reset; the user guards them with its own valid flag.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data <= rsta ? '0 : mem[addra];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_lat
    assign douta = ram_data;
  end else begin : g_high_perf
    logic [RAM_WIDTH-1:0] douta_reg;
    always_ff @(posedge clka) begin
      if (rsta)     douta_reg <= '0;
      else if (ena) douta_reg <= ram_data;
    end
    assign douta = douta_reg;
  end

endmodule

// File: rtl/overlap_add.sv
// 50%-overlap frame reconstruction: front half of each frame + stored tail of the previous frame.
// Latency: 2 cycles from accepted sample (or flush request) to out_valid.
// Backpressure: in_ready drops only during a tail flush (HOP+... cycles); no output stall.
// Ports: clk_in/rst_n_in clock and async reset; in_sample/in_valid/in_first/in_ready
//        sample stream; flush_in drain request; out_sample/out_valid result strobe.
module overlap_add
  import overlap_add_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4096
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  input  logic                         in_first,
  output logic                         in_ready,
  input  logic                         flush_in,
  output logic signed [DATA_WIDTH-1:0] out_sample,
  output logic                         out_valid
);

  localparam int HOP = FRAME_LEN / 2;
  localparam int IW  = $clog2(FRAME_LEN);
  localparam int AW  = IW - 1;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         tail_valid_q, tail_valid_d;
  logic [AW-1:0]                fcnt_q, fcnt_d;
  logic                         s1_vld_q, s1_vld_d;
  logic signed [DATA_WIDTH-1:0] s1_sample_q, s1_sample_d;
  logic                         s1_use_q, s1_use_d;
  logic signed [DATA_WIDTH-1:0] out_sample_q, out_sample_d;
  logic                         out_valid_q;

  logic                         flush_go, accept, discard;
  logic [IW-1:0]                eff_idx;
  logic                         ram_en, ram_we;
  logic [AW-1:0]                ram_addr;
  logic [DATA_WIDTH-1:0]        ram_dout;
  logic signed [DATA_WIDTH:0]   tail_ext, sum;

  // A flush is only meaningful on a frame boundary with a live tail; it
  // wins over a sample offered in the same cycle.
  assign flush_go = (state_q == ACCUM) && flush_in && (idx_q == '0) && tail_valid_q;
  assign in_ready = (state_q == ACCUM) && !flush_go;
  assign accept   = in_valid && in_ready;
  assign discard  = accept && in_first && (idx_q != '0);
  assign eff_idx  = in_first ? '0 : idx_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tail_valid_d = tail_valid_q;
    fcnt_d       = fcnt_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    s1_vld_d     = 1'b0;
    s1_sample_d  = '0;
    s1_use_d     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (flush_go) begin
          // Tail entry 0 is read in the flush cycle itself, so the drain
          // output lines up 2 cycles later like a normal sample.
          state_d  = FLUSH;
          fcnt_d   = AW'(1);
          ram_en   = 1'b1;
          s1_vld_d = 1'b1;
          s1_use_d = 1'b1;
        end else if (accept) begin
          idx_d    = eff_idx + 1'b1;
          ram_en   = 1'b1;
          ram_addr = eff_idx[AW-1:0];
          if (discard)                           tail_valid_d = 1'b0;
          if (eff_idx == IW'(FRAME_LEN - 1))     tail_valid_d = 1'b1;
          // MSB of idx separates the front half (overlap-add) from the
          // back half (stored as the next frame's tail).
          if (eff_idx[IW-1]) begin
            ram_we = 1'b1;
          end else begin
            s1_vld_d    = 1'b1;
            s1_sample_d = in_sample;
            s1_use_d    = tail_valid_q && !discard;
          end
        end
      end
      FLUSH: begin
        ram_en   = 1'b1;
        ram_addr = fcnt_q;
        s1_vld_d = 1'b1;
        s1_use_d = 1'b1;
        fcnt_d   = fcnt_q + 1'b1;
        if (fcnt_q == AW'(HOP - 1)) begin
          tail_valid_d = 1'b0;
          state_d      = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH      (DATA_WIDTH),
    .RAM_DEPTH      (HOP),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_tail_ram (
    .clka (clk_in),
    .ena  (ram_en),
    .wea  (ram_we),
    .rsta (1'b0),
    .addra(ram_addr),
    .dina (in_sample),
    .douta(ram_dout)
  );

  // Flush entries carry a zero sample, so they pass through unchanged.
  always_comb begin
    tail_ext     = s1_use_q ? (DATA_WIDTH+1)'(signed'(ram_dout)) : '0;
    sum          = (DATA_WIDTH+1)'(s1_sample_q) + tail_ext;
    out_sample_d = out_sample_q;
    if (s1_vld_q) out_sample_d = DATA_WIDTH'(sat_s((SAT_MAXW+1)'(sum), DATA_WIDTH));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ACCUM;
      idx_q        <= '0;
      tail_valid_q <= 1'b0;
      fcnt_q       <= '0;
      s1_vld_q     <= 1'b0;
      s1_sample_q  <= '0;
      s1_use_q     <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tail_valid_q <= tail_valid_d;
      fcnt_q       <= fcnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_sample_q  <= s1_sample_d;
      s1_use_q     <= s1_use_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= s1_vld_q;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;

endmodule
